// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one read per cycle to a synchronous-read
// instruction memory and buffers {word, pc} pairs in a small FIFO toward decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [0:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [31:0]      fifo_data_d [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]      fifo_pc_d   [FIFO_DEPTH];

    logic             pop;
    logic             push;
    logic [OCC_W-1:0] occupancy;

    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid && inst_ready;
    // A redirect in the same cycle kills the response belonging to the old stream.
    assign push       = inflight_q && !redirect_valid;

    // Credit check: buffered words plus the outstanding response, less the word leaving now.
    assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);

    assign imem_req  = (state_q == ST_RUN) && fetch_en && !redirect_valid &&
                       (occupancy < OCC_W'(FIFO_DEPTH));
    assign imem_addr = pc_q;

    assign inst_data = inst_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign inst_pc   = inst_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;

    always_comb begin
        state_d       = fetch_en ? ST_RUN : ST_IDLE;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fifo_data_d   = fifo_data_q;
        fifo_pc_d     = fifo_pc_q;

        if (imem_req) begin
            pc_d          = pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end

        if (push) begin
            fifo_data_d[wr_ptr_q] = imem_rdata;
            fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (redirect_valid) begin
            pc_d       = redirect_pc & ALIGN_MASK;
            inflight_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC & ALIGN_MASK;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only exposed while count_q says they are valid.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_pc_q   <= fifo_pc_d;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: two instances (RESET_PC 0 and FFFF_FFF8), each with a
// synchronous-read memory whose word at byte address a is a>>2.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        fetch_en, redirect_valid, inst_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc;

    logic        fetch_en2, inst_ready2;
    logic        imem_req2, inst_valid2;
    logic [31:0] imem_addr2, imem_rdata2, inst_data2, inst_pc2;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_pc;

    fetch_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    fetch_sequencer #(
        .RESET_PC   (32'hFFFF_FFF8),
        .FIFO_DEPTH (2)
    ) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem_req       (imem_req2),
        .imem_addr      (imem_addr2),
        .imem_rdata     (imem_rdata2),
        .inst_valid     (inst_valid2),
        .inst_ready     (inst_ready2),
        .inst_data      (inst_data2),
        .inst_pc        (inst_pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Garbage on unrequested cycles exposes any push without a matching issue.
    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? (imem_addr  >> 2) : 32'hDEAD_BEEF;
        imem_rdata2 <= imem_req2 ? (imem_addr2 >> 2) : 32'hDEAD_BEEF;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    // Every accepted instruction must be the next one in program order.
    task automatic adv();
        if (inst_valid && inst_ready) begin
            check_eq("stream_pc", inst_pc, exp_pc);
            check_eq("stream_data", inst_data, exp_pc >> 2);
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        exp_pc         = 32'h0;
        rst            = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        fetch_en2      = 1'b0;
        inst_ready2    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        settle();
        check_eq("rst_req", 32'(imem_req), 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_valid", 32'(inst_valid), 32'h0);
        check_eq("rst_data", inst_data, 32'h0);
        check_eq("rst_pc", inst_pc, 32'h0);
        check_eq("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);
        adv();

        // Enable: registered state transition delays the first issue by one cycle
        fetch_en = 1'b1;
        settle();
        check_eq("en_first_cycle_req", 32'(imem_req), 32'h0);
        adv();
        settle();
        check_eq("first_issue_req", 32'(imem_req), 32'h1);
        check_eq("first_issue_addr", imem_addr, 32'h0);
        adv();
        settle();
        check_eq("second_issue_addr", imem_addr, 32'h4);
        check_eq("latency_valid_low", 32'(inst_valid), 32'h0);
        adv();
        for (int k = 3; k <= 7; k++) begin
            settle();
            check_eq("no_bubble_valid", 32'(inst_valid), 32'h1);
            check_eq("stream_addr", imem_addr, 32'(4 * (k - 1)));
            adv();
        end

        // Back-pressure for 5 cycles: FIFO fills, issue stops, head holds
        inst_ready = 1'b0;
        settle();
        check_eq("stall_req", 32'(imem_req), 32'h0);
        check_eq("stall_head_pc", inst_pc, 32'd20);
        adv();
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq("stall_req_hold", 32'(imem_req), 32'h0);
            check_eq("stall_valid", 32'(inst_valid), 32'h1);
            check_eq("stall_head_pc", inst_pc, 32'd20);
            check_eq("stall_head_data", inst_data, 32'd5);
            adv();
        end
        inst_ready = 1'b1;
        settle();
        check_eq("release_req", 32'(imem_req), 32'h1);
        check_eq("release_addr", imem_addr, 32'd28);
        adv();
        settle();
        check_eq("release_addr2", imem_addr, 32'd32);
        adv();
        settle();
        adv();

        // Redirect with one buffered entry and a response in flight
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        settle();
        check_eq("redir_no_issue", 32'(imem_req), 32'h0);
        adv();
        exp_pc         = 32'h100;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        settle();
        check_eq("redir_flush_valid", 32'(inst_valid), 32'h0);
        check_eq("redir_issue_req", 32'(imem_req), 32'h1);
        check_eq("redir_issue_addr", imem_addr, 32'h100);
        adv();
        settle();
        check_eq("redir_t2_valid", 32'(inst_valid), 32'h0);
        check_eq("redir_t2_addr", imem_addr, 32'h104);
        adv();
        settle();
        check_eq("redir_t3_valid", 32'(inst_valid), 32'h1);
        check_eq("redir_t3_pc", inst_pc, 32'h100);
        check_eq("redir_t3_data", inst_data, 32'h40);
        adv();

        // fetch_en drop with a response in flight
        fetch_en = 1'b0;
        settle();
        check_eq("en_low_no_issue", 32'(imem_req), 32'h0);
        adv();
        settle();
        check_eq("inflight_delivered_valid", 32'(inst_valid), 32'h1);
        check_eq("inflight_delivered_pc", inst_pc, 32'h108);
        check_eq("en_low_req", 32'(imem_req), 32'h0);
        adv();
        fetch_en = 1'b1;
        settle();
        check_eq("drained_valid", 32'(inst_valid), 32'h0);
        check_eq("idle_req", 32'(imem_req), 32'h0);
        adv();
        settle();
        check_eq("resume_req", 32'(imem_req), 32'h1);
        check_eq("resume_addr", imem_addr, 32'h10C);
        adv();
        settle();
        check_eq("resume_gap_valid", 32'(inst_valid), 32'h0);
        adv();
        settle();
        check_eq("resume_pc", inst_pc, 32'h10C);
        adv();

        // Back-to-back redirects: the last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        settle();
        adv();
        exp_pc      = 32'h400;
        redirect_pc = 32'h0000_0402;
        settle();
        check_eq("redir2_valid", 32'(inst_valid), 32'h0);
        adv();
        redirect_valid = 1'b0;
        settle();
        check_eq("redir2_addr", imem_addr, 32'h400);
        adv();
        settle();
        adv();
        settle();
        check_eq("redir2_first_pc", inst_pc, 32'h400);
        adv();

        // Synchronous reset with a buffered entry and a response arriving
        inst_ready = 1'b0;
        rst        = 1'b1;
        settle();
        adv();
        rst        = 1'b0;
        inst_ready = 1'b1;
        exp_pc     = 32'h0;
        settle();
        check_eq("midrst_valid", 32'(inst_valid), 32'h0);
        check_eq("midrst_req", 32'(imem_req), 32'h0);
        check_eq("midrst_addr", imem_addr, 32'h0);
        adv();
        settle();
        check_eq("midrst_stale_valid", 32'(inst_valid), 32'h0);
        check_eq("midrst_issue_addr", imem_addr, 32'h0);
        adv();
        settle();
        check_eq("midrst_stale_valid2", 32'(inst_valid), 32'h0);
        adv();
        settle();
        check_eq("midrst_first_pc", inst_pc, 32'h0);
        adv();

        // PC wrap from FFFF_FFF8
        fetch_en2 = 1'b1;
        settle();
        check_eq("wrap_idle_req", 32'(imem_req2), 32'h0);
        adv();
        settle();
        check_eq("wrap_addr0", imem_addr2, 32'hFFFF_FFF8);
        adv();
        settle();
        check_eq("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
        adv();
        settle();
        check_eq("wrap_addr2", imem_addr2, 32'h0000_0000);
        check_eq("wrap_pc0", inst_pc2, 32'hFFFF_FFF8);
        check_eq("wrap_data0", inst_data2, 32'h3FFF_FFFE);
        adv();
        settle();
        check_eq("wrap_pc1", inst_pc2, 32'hFFFF_FFFC);
        check_eq("wrap_data1", inst_data2, 32'h3FFF_FFFF);
        adv();
        settle();
        check_eq("wrap_pc2", inst_pc2, 32'h0000_0000);
        check_eq("wrap_data2", inst_data2, 32'h0);
        adv();
        settle();
        check_eq("wrap_pc3", inst_pc2, 32'h0000_0004);
        check_eq("wrap_data3", inst_data2, 32'h1);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
